// File: rtl/multi_warp_fetcher.sv
// Multi-warp instruction fetcher: per-warp IDLE/PENDING/FETCHED channels sharing one memory port via a round-robin arbiter.
// Optional macro MWF_PERF_COUNTERS_EN adds saturating stall and completed-fetch counters.
module multi_warp_fetcher #(
    parameter int NUM_WARPS   = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WARPS-1:0]             fetch_req,
    input  logic [NUM_WARPS*ADDR_WIDTH-1:0]  pc,
    input  logic [NUM_WARPS-1:0]             fetch_ack,
    output logic                             instruction_mem_read_valid,
    output logic [ADDR_WIDTH-1:0]            instruction_mem_read_address,
    input  logic                             instruction_mem_read_ready,
    input  logic [INSTR_WIDTH-1:0]           instruction_mem_read_data,
    output logic [NUM_WARPS-1:0]             fetch_done,
    output logic [NUM_WARPS*INSTR_WIDTH-1:0] instruction
`ifdef MWF_PERF_COUNTERS_EN
    ,
    output logic [31:0]                      mem_stall_cycles,
    output logic [31:0]                      fetch_count
`endif
);

    localparam int PTR_W = $clog2(NUM_WARPS);

    typedef enum logic [1:0] {W_IDLE, W_PENDING, W_FETCHED} warp_state_e;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

    warp_state_e            r_wstate     [NUM_WARPS];
    warp_state_e            w_wstate_nxt [NUM_WARPS];
    arb_state_e             r_arb_state;
    arb_state_e             w_arb_nxt;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_grant;
    logic [PTR_W-1:0]       w_grant_idx;
    logic [PTR_W-1:0]       w_cand;
    logic                   w_grant_found;
    logic                   w_capture;
    logic [ADDR_WIDTH-1:0]  r_pc    [NUM_WARPS];
    logic [INSTR_WIDTH-1:0] r_instr [NUM_WARPS];
    logic                   r_valid;
    logic [ADDR_WIDTH-1:0]  r_addr;

    // Ready only matters while a request is actually on the bus.
    assign w_capture = r_valid && instruction_mem_read_ready;

    // Round-robin search from r_ptr; descending loop so the closest candidate wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = r_ptr;
        w_cand        = r_ptr;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            w_cand = r_ptr + PTR_W'(i);
            if (r_wstate[w_cand] == W_PENDING) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_arb_nxt = r_arb_state;
        case (r_arb_state)
            ARB_IDLE: if (w_grant_found) w_arb_nxt = ARB_BUSY;
            ARB_BUSY: if (w_capture)     w_arb_nxt = ARB_IDLE;
            default:  w_arb_nxt = ARB_IDLE;
        endcase
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_wstate_nxt[w] = r_wstate[w];
            case (r_wstate[w])
                W_IDLE:    if (fetch_req[w]) w_wstate_nxt[w] = W_PENDING;
                W_PENDING: if (w_capture && (r_grant == PTR_W'(w))) w_wstate_nxt[w] = W_FETCHED;
                W_FETCHED: if (fetch_ack[w]) w_wstate_nxt[w] = W_IDLE;
                default:   w_wstate_nxt[w] = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_arb_state <= ARB_IDLE;
            for (int w = 0; w < NUM_WARPS; w++) r_wstate[w] <= W_IDLE;
        end else begin
            r_arb_state <= w_arb_nxt;
            for (int w = 0; w < NUM_WARPS; w++) r_wstate[w] <= w_wstate_nxt[w];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_pc[w]    <= '0;
                r_instr[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (r_wstate[w] == W_IDLE && fetch_req[w])
                    r_pc[w] <= pc[w*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (r_arb_state == ARB_IDLE && w_grant_found) begin
                r_grant <= w_grant_idx;
                r_ptr   <= w_grant_idx + PTR_W'(1);
                r_valid <= 1'b1;
                r_addr  <= r_pc[w_grant_idx];
            end
            if (w_capture) begin
                r_valid          <= 1'b0;
                r_instr[r_grant] <= instruction_mem_read_data;
            end
        end
    end

`ifdef MWF_PERF_COUNTERS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_fetch_cnt <= '0;
        end else begin
            if (r_valid && !instruction_mem_read_ready && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_capture && r_fetch_cnt != 32'hFFFF_FFFF)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign mem_stall_cycles = r_stall_cnt;
    assign fetch_count      = r_fetch_cnt;
`endif

    assign instruction_mem_read_valid   = r_valid;
    assign instruction_mem_read_address = r_addr;

    always_comb begin
        fetch_done  = '0;
        instruction = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            fetch_done[w]                               = (r_wstate[w] == W_FETCHED);
            instruction[w*INSTR_WIDTH +: INSTR_WIDTH]   = r_instr[w];
        end
    end

endmodule

// File: tb/tb_multi_warp_fetcher.sv
// Bench for multi_warp_fetcher: directed scenarios then random traffic, all checked against a transaction-level model.
module tb_multi_warp_fetcher;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int IW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    fetch_req = '0;
    logic [N*AW-1:0] pc = '0;
    logic [N-1:0]    fetch_ack = '0;
    logic            mem_valid;
    logic [AW-1:0]   mem_addr;
    logic            mem_ready = 1'b0;
    logic [IW-1:0]   mem_data = '0;
    logic [N-1:0]    fetch_done;
    logic [N*IW-1:0] instruction;
`ifdef MWF_PERF_COUNTERS_EN
    logic [31:0]     mem_stall_cycles;
    logic [31:0]     fetch_count;
`endif

    multi_warp_fetcher #(.NUM_WARPS(N), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
        .clk                          (clk),
        .reset                        (reset),
        .fetch_req                    (fetch_req),
        .pc                           (pc),
        .fetch_ack                    (fetch_ack),
        .instruction_mem_read_valid   (mem_valid),
        .instruction_mem_read_address (mem_addr),
        .instruction_mem_read_ready   (mem_ready),
        .instruction_mem_read_data    (mem_data),
        .fetch_done                   (fetch_done),
        .instruction                  (instruction)
`ifdef MWF_PERF_COUNTERS_EN
        ,
        .mem_stall_cycles             (mem_stall_cycles),
        .fetch_count                  (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: which warps wait, which hold a result, and the single in-flight transaction.
    bit            m_pend [N];
    bit            m_done [N];
    logic [AW-1:0] m_pc   [N];
    logic [IW-1:0] m_ins  [N];
    bit            m_busy;
    int            m_gw;
    int            m_next;
    logic [AW-1:0] m_addr;
    longint        m_stall;
    longint        m_fcnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit old_pend [N];
        bit old_done [N];
        for (int w = 0; w < N; w++) begin
            old_pend[w] = m_pend[w];
            old_done[w] = m_done[w];
        end
        if (reset) begin
            for (int w = 0; w < N; w++) begin
                m_pend[w] = 0; m_done[w] = 0; m_ins[w] = '0;
            end
            m_busy = 0; m_next = 0; m_addr = '0; m_stall = 0; m_fcnt = 0;
        end else begin
            if (m_busy) begin
                if (mem_ready) begin
                    m_done[m_gw] = 1; m_pend[m_gw] = 0; m_ins[m_gw] = mem_data; m_busy = 0;
                    if (m_fcnt < 64'hFFFF_FFFF) m_fcnt++;
                end else if (m_stall < 64'hFFFF_FFFF) m_stall++;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int w;
                    w = (m_next + k) % N;
                    if (old_pend[w]) begin
                        m_gw = w; m_busy = 1; m_addr = m_pc[w]; m_next = (w + 1) % N;
                        break;
                    end
                end
            end
            for (int w = 0; w < N; w++) begin
                if (!old_pend[w] && !old_done[w] && fetch_req[w]) begin
                    m_pend[w] = 1;
                    m_pc[w]   = pc[w*AW +: AW];
                end else if (old_done[w] && fetch_ack[w]) begin
                    m_done[w] = 0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("valid", 64'(mem_valid), 64'(m_busy));
        if (m_busy) chk("address", 64'(mem_addr), 64'(m_addr));
        for (int w = 0; w < N; w++) begin
            chk($sformatf("fetch_done[%0d]", w), 64'(fetch_done[w]), 64'(m_done[w]));
            if (m_done[w])
                chk($sformatf("instruction[%0d]", w), 64'(instruction[w*IW +: IW]), 64'(m_ins[w]));
        end
`ifdef MWF_PERF_COUNTERS_EN
        chk("mem_stall_cycles", 64'(mem_stall_cycles), 64'(m_stall));
        chk("fetch_count", 64'(fetch_count), 64'(m_fcnt));
`endif
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    logic [AW-1:0] grants [$];
    bit            prev_valid;

    task automatic watch_grants(input int ncyc);
        grants.delete();
        prev_valid = mem_valid;
        for (int c = 0; c < ncyc; c++) begin
            cyc();
            if (mem_valid && !prev_valid) grants.push_back(mem_addr);
            prev_valid = mem_valid;
        end
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        cyc();
        cyc();
        chk("reset_valid", 64'(mem_valid), 64'd0);
        chk("reset_address", 64'(mem_addr), 64'd0);
        chk("reset_done", 64'(fetch_done), 64'd0);
        chk("reset_instr", 64'(instruction[63:0]), 64'd0);
        chk("reset_instr_hi", 64'(instruction[N*IW-1:64]), 64'd0);
        reset = 1'b0;

        // Single fetch on warp 1
        mem_ready = 1'b1;
        mem_data  = 32'hDEAD_BEEF;
        fetch_req[1] = 1'b1;
        pc[1*AW +: AW] = 12'h040;
        cyc();
        fetch_req = '0;
        chk("single_no_early_valid", 64'(mem_valid), 64'd0);
        cyc();
        chk("single_valid", 64'(mem_valid), 64'd1);
        chk("single_addr", 64'(mem_addr), 64'h040);
        cyc();
        chk("single_valid_drop", 64'(mem_valid), 64'd0);
        chk("single_done", 64'(fetch_done[1]), 64'd1);
        chk("single_instr", 64'(instruction[1*IW +: IW]), 64'hDEAD_BEEF);
        mem_data = 32'h1234_5678;
        cyc();
        cyc();
        chk("single_hold_done", 64'(fetch_done[1]), 64'd1);
        chk("single_hold_instr", 64'(instruction[1*IW +: IW]), 64'hDEAD_BEEF);
        fetch_ack[1] = 1'b1;
        cyc();
        fetch_ack = '0;
        chk("single_ack", 64'(fetch_done[1]), 64'd0);

        // Round-robin from a fresh pointer
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int w = 0; w < N; w++) pc[w*AW +: AW] = AW'(12'h100 + w);
        fetch_req = '1;
        mem_data  = $urandom;
        cyc();
        fetch_req = '0;
        watch_grants(10);
        chk("rr_count", 64'(grants.size()), 64'd4);
        for (int i = 0; i < grants.size() && i < N; i++)
            chk($sformatf("rr_order%0d", i), 64'(grants[i]), 64'(12'h100 + i));
        fetch_ack = '1;
        cyc();
        fetch_ack = '0;
        pc[0*AW +: AW] = 12'h200;
        pc[3*AW +: AW] = 12'h203;
        fetch_req = 4'b1001;
        cyc();
        fetch_req = '0;
        watch_grants(6);
        chk("rr2_count", 64'(grants.size()), 64'd2);
        if (grants.size() == 2) begin
            chk("rr2_first", 64'(grants[0]), 64'h200);
            chk("rr2_second", 64'(grants[1]), 64'h203);
        end
        fetch_ack = '1;
        cyc();
        fetch_ack = '0;

        // Memory stall: five not-ready cycles then capture
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mem_ready = 1'b0;
        fetch_req[0] = 1'b1;
        pc[0*AW +: AW] = 12'h2A0;
        cyc();
        fetch_req = '0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            mem_data = $urandom;
            cyc();
            chk("stall_valid", 64'(mem_valid), 64'd1);
            chk("stall_addr", 64'(mem_addr), 64'h2A0);
        end
        mem_ready = 1'b1;
        mem_data  = 32'hCAFE_F00D;
        cyc();
        chk("stall_capture", 64'(instruction[0 +: IW]), 64'hCAFE_F00D);
`ifdef MWF_PERF_COUNTERS_EN
        chk("stall_perf_stalls", 64'(mem_stall_cycles), 64'd5);
        chk("stall_perf_fetches", 64'(fetch_count), 64'd1);
`endif
        fetch_ack = '1;
        cyc();
        fetch_ack = '0;

        // PC change after latching, then ready pulses with nothing on the bus
        fetch_req[2] = 1'b1;
        pc[2*AW +: AW] = 12'h333;
        cyc();
        fetch_req = '0;
        pc[2*AW +: AW] = 12'h555;
        cyc();
        chk("pc_latched_addr", 64'(mem_addr), 64'h333);
        cyc();
        for (int i = 0; i < 4; i++) begin
            mem_ready = i[0];
            mem_data  = $urandom;
            cyc();
            chk("idle_ready_done", 64'(fetch_done), 64'b0100);
        end
        fetch_ack[2] = 1'b1;
        cyc();
        fetch_ack = '0;

        // Reset while busy; ready right after reset must be ignored
        mem_ready = 1'b0;
        fetch_req[1] = 1'b1;
        pc[1*AW +: AW] = 12'h111;
        cyc();
        fetch_req = '0;
        cyc();
        chk("rst_busy_valid", 64'(mem_valid), 64'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_data  = 32'hBAD0_BAD0;
        cyc();
        chk("rst_after_valid", 64'(mem_valid), 64'd0);
        chk("rst_after_done", 64'(fetch_done), 64'd0);
        chk("rst_after_instr", 64'(instruction[63:0]), 64'd0);
        chk("rst_after_instr_hi", 64'(instruction[N*IW-1:64]), 64'd0);
        fetch_req[2] = 1'b1;
        pc[2*AW +: AW] = 12'h222;
        cyc();
        fetch_req = '0;
        cyc();
        chk("rst_next_valid", 64'(mem_valid), 64'd1);
        chk("rst_next_addr", 64'(mem_addr), 64'h222);
        cyc();

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            reset     = ($urandom_range(0, 63) == 0);
            fetch_req = N'($urandom);
            fetch_ack = N'($urandom);
            mem_ready = ($urandom_range(0, 9) < 6);
            mem_data  = $urandom;
            pc        = (N*AW)'({$urandom(), $urandom()});
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
